debug_regsnap: RTL and testbench



---
 rtl/debug_regsnap_pkg.sv | 35 +++
 rtl/debug_regsnap_buf.sv | 52 +++++
 rtl/debug_regsnap.sv | 169 ++++++++++++++++
 tb/tb_debug_regsnap.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_regsnap_pkg.sv
// Shared definitions for the debug register-snapshot sequencer.
// Holds the sequencer state encodings, the ALU debug-port register indices
// and the default number of scanned registers.
package debug_regsnap_pkg;

   // Number of ALU registers visible on the debug port.
   localparam int unsigned NUM_ALU_REGS = 16;

   // ALU debug-port register indices.
   localparam logic [3:0] REG_MAG  = 4'd0;
   localparam logic [3:0] REG_PC   = 4'd1;
   localparam logic [3:0] REG_HR   = 4'd2;
   localparam logic [3:0] REG_AR   = 4'd3;
   localparam logic [3:0] REG_ARX  = 4'd4;
   localparam logic [3:0] REG_BR   = 4'd5;
   localparam logic [3:0] REG_BRX  = 4'd6;
   localparam logic [3:0] REG_ONE  = 4'd7;
   localparam logic [3:0] REG_EBR  = 4'd8;
   localparam logic [3:0] REG_UBR  = 4'd9;
   localparam logic [3:0] REG_MASK = 4'd10;
   localparam logic [3:0] REG_FLG  = 4'd11;
   localparam logic [3:0] REG_PI   = 4'd12;
   localparam logic [3:0] REG_XWD1 = 4'd13;
   localparam logic [3:0] REG_T0   = 4'd14;
   localparam logic [3:0] REG_T1   = 4'd15;

   // Sequencer states.
   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSetup  = 2'd1,
      StSample = 2'd2,
      StFinish = 2'd3
   } snap_state_e;

endpackage

// File: rtl/debug_regsnap_buf.sv
// Snapshot buffer: NREGS x 36-bit register file.
// Ports:
//   clk, rst   - clock, asynchronous active-high clear of every word
//   we         - synchronous write enable (already clock-enable qualified)
//   waddr      - write index
//   wdata      - write data
//   raddr      - asynchronous read index (out-of-range indices read as 0)
//   rdata      - read data
module debug_regsnap_buf
   import debug_regsnap_pkg::*;
#(
   parameter int unsigned NREGS = NUM_ALU_REGS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [3:0]  waddr,
   input  logic [0:35] wdata,
   input  logic [3:0]  raddr,
   output logic [0:35] rdata
);

   logic [0:35] mem_q [NREGS];
   logic [0:35] mem_d [NREGS];

   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < int'(NREGS); i++) begin
         if (we && (int'(waddr) == i)) begin
            mem_d[i] = wdata;
         end
      end
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < int'(NREGS); i++) begin
         if (int'(raddr) == i) begin
            rdata = mem_q[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/debug_regsnap.sv
// Debug register-snapshot sequencer.
// Owns the ALU debug read port and shares it between live PC tracking (port
// parked at PCREG) and a console-initiated scan of all ALU registers into a
// local buffer while the CPU is halted.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   clken         - qualifies every state, counter and buffer update
//   loadIR        - instruction load this cycle
//   cpuHALT       - CPU halted (level)
//   snapREQ       - console snapshot request
//   debugDATA     - ALU data for the address set on the previous clken cycle
//   debugADDR     - registered ALU register select
//   rdADDR/rdDATA - combinational console read of the snapshot buffer
//   pcOUT         - last captured PC
//   instCOUNT     - instructions loaded (wrapping)
//   snapBUSY      - scan in progress
//   snapVALID     - buffer holds a complete snapshot
//   snapDONE      - one-clk pulse on scan completion
//   snapABORT     - one-clk pulse when a scan is abandoned
module debug_regsnap
   import debug_regsnap_pkg::*;
#(
   parameter int unsigned NREGS = NUM_ALU_REGS,
   parameter int unsigned PCREG = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clken,
   input  logic         loadIR,
   input  logic         cpuHALT,
   input  logic         snapREQ,
   input  logic [0:35]  debugDATA,
   output logic [0:3]   debugADDR,
   input  logic [0:3]   rdADDR,
   output logic [0:35]  rdDATA,
   output logic [18:35] pcOUT,
   output logic [0:31]  instCOUNT,
   output logic         snapBUSY,
   output logic         snapVALID,
   output logic         snapDONE,
   output logic         snapABORT
);

   localparam logic [3:0] PcAddr  = 4'(PCREG);
   localparam logic [3:0] LastIdx = 4'(NREGS - 1);

   snap_state_e state_q, state_d;
   logic [3:0]  index_q, index_d;
   logic [3:0]  addr_q, addr_d;
   logic        pend_q, pend_d;
   logic        valid_q, valid_d;
   logic        done_q, done_d;
   logic        abort_q, abort_d;
   logic [17:0] pc_q, pc_d;
   logic [31:0] cnt_q, cnt_d;
   logic        buf_we;

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      pend_d  = pend_q;
      valid_d = valid_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      abort_d = 1'b0;
      buf_we  = 1'b0;

      if (clken) begin
         if (loadIR) begin
            cnt_d = cnt_q + 32'd1;
         end

         unique case (state_q)
            StIdle: begin
               // Port is parked at PCREG here, so debugDATA is the PC.
               if (loadIR) begin
                  pc_d = debugDATA[18:35];
               end
               if ((pend_q || snapREQ) && cpuHALT) begin
                  index_d = '0;
                  pend_d  = 1'b0;
                  valid_d = 1'b0;
                  state_d = StSetup;
               end else if (snapREQ) begin
                  pend_d = 1'b1;
               end
            end
            StSetup: begin
               if (!cpuHALT) begin
                  abort_d = 1'b1;
                  state_d = StIdle;
               end else begin
                  state_d = StSample;
               end
            end
            StSample: begin
               if (!cpuHALT) begin
                  abort_d = 1'b1;
                  state_d = StIdle;
               end else begin
                  buf_we = 1'b1;
                  if (index_q == LastIdx) begin
                     state_d = StFinish;
                  end else begin
                     index_d = index_q + 4'd1;
                     state_d = StSetup;
                  end
               end
            end
            StFinish: begin
               valid_d = 1'b1;
               done_d  = 1'b1;
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end

      // Address follows the state being entered, so the data arrives one
      // clken cycle after the address is set.
      addr_d = (state_d == StIdle) ? PcAddr : index_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         index_q <= '0;
         addr_q  <= PcAddr;
         pend_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
         pc_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         addr_q  <= addr_d;
         pend_q  <= pend_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         abort_q <= abort_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   debug_regsnap_buf #(
      .NREGS (NREGS)
   ) u_buf (
      .clk   (clk),
      .rst   (rst),
      .we    (buf_we),
      .waddr (index_q),
      .wdata (debugDATA),
      .raddr (rdADDR),
      .rdata (rdDATA)
   );

   assign debugADDR = addr_q;
   assign pcOUT     = pc_q;
   assign instCOUNT = cnt_q;
   assign snapBUSY  = (state_q != StIdle);
   assign snapVALID = valid_q;
   assign snapDONE  = done_q;
   assign snapABORT = abort_q;

endmodule

// File: tb/tb_debug_regsnap.sv
// Directed bench for debug_regsnap: PC capture, full scan, pending request,
// abort, counter wrap, asynchronous reset mid-scan and clock-enable freeze.
module tb_debug_regsnap;

   logic         clk = 1'b0;
   logic         rst;
   logic         clken;
   logic         loadIR;
   logic         cpuHALT;
   logic         snapREQ;
   logic [0:35]  debugDATA;
   logic [0:3]   debugADDR;
   logic [0:3]   rdADDR;
   logic [0:35]  rdDATA;
   logic [18:35] pcOUT;
   logic [0:31]  instCOUNT;
   logic         snapBUSY;
   logic         snapVALID;
   logic         snapDONE;
   logic         snapABORT;

   // ALU model: either a fixed word or base + currently selected address.
   logic         model_en;
   logic [0:35]  data_base;
   logic [0:35]  data_fixed;

   int n_tests = 0;
   int n_fail  = 0;
   int n_cyc;

   always #5 clk = ~clk;

   always_comb debugDATA = model_en ? (data_base + 36'(debugADDR)) : data_fixed;

   debug_regsnap dut (
      .clk       (clk),
      .rst       (rst),
      .clken     (clken),
      .loadIR    (loadIR),
      .cpuHALT   (cpuHALT),
      .snapREQ   (snapREQ),
      .debugDATA (debugDATA),
      .debugADDR (debugADDR),
      .rdADDR    (rdADDR),
      .rdDATA    (rdDATA),
      .pcOUT     (pcOUT),
      .instCOUNT (instCOUNT),
      .snapBUSY  (snapBUSY),
      .snapVALID (snapVALID),
      .snapDONE  (snapDONE),
      .snapABORT (snapABORT)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until DONE or ABORT, bounded; n counts edges taken.
   task automatic wait_end(input int max, output int n);
      n = 0;
      do begin
         tick();
         loadIR = 1'b0;
         n++;
      end while (!snapDONE && !snapABORT && n < max);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      clken      = 1'b1;
      loadIR     = 1'b0;
      cpuHALT    = 1'b0;
      snapREQ    = 1'b0;
      rdADDR     = 4'd3;
      model_en   = 1'b0;
      data_base  = '0;
      data_fixed = '0;
      tick();
      tick();

      check("rst_addr",  64'(debugADDR), 64'd1);
      check("rst_pc",    64'(pcOUT),     64'd0);
      check("rst_cnt",   64'(instCOUNT), 64'd0);
      check("rst_busy",  64'(snapBUSY),  64'd0);
      check("rst_valid", 64'(snapVALID), 64'd0);
      check("rst_done",  64'(snapDONE),  64'd0);
      check("rst_abort", 64'(snapABORT), 64'd0);
      check("rst_buf",   64'(rdDATA),    64'd0);
      rst = 1'b0;

      // PC capture in IDLE.
      data_fixed = 36'o000000030057;
      loadIR = 1'b1;
      tick();
      loadIR = 1'b0;
      check("pc_capture", 64'(pcOUT),     64'o030057);
      check("pc_count",   64'(instCOUNT), 64'd1);
      check("pc_addr",    64'(debugADDR), 64'd1);

      // Full scan; a loadIR in SETUP must count but not capture.
      model_en  = 1'b1;
      data_base = 36'o1000000;
      cpuHALT   = 1'b1;
      snapREQ   = 1'b1;
      tick();
      snapREQ = 1'b0;
      check("scan_busy",  64'(snapBUSY),  64'd1);
      check("scan_addr0", 64'(debugADDR), 64'd0);
      loadIR = 1'b1;
      wait_end(60, n_cyc);
      check("scan_len",   64'(n_cyc),     64'd33);
      check("scan_done",  64'(snapDONE),  64'd1);
      check("scan_valid", 64'(snapVALID), 64'd1);
      check("scan_idle",  64'(snapBUSY),  64'd0);
      check("scan_ret",   64'(debugADDR), 64'd1);
      check("scan_pc",    64'(pcOUT),     64'o030057);
      check("scan_cnt",   64'(instCOUNT), 64'd2);
      rdADDR = 4'd5;
      #1;
      check("scan_rd5",   64'(rdDATA),    64'o1000005);
      rdADDR = 4'd15;
      #1;
      check("scan_rd15",  64'(rdDATA),    64'o1000017);
      tick();
      check("done_pulse", 64'(snapDONE),  64'd0);

      // Request while running pends until halt.
      cpuHALT   = 1'b0;
      data_base = 36'o2000000;
      snapREQ   = 1'b1;
      tick();
      snapREQ = 1'b0;
      repeat (9) tick();
      check("pend_wait",  64'(snapBUSY),  64'd0);
      check("pend_valid", 64'(snapVALID), 64'd1);
      cpuHALT = 1'b1;
      tick();
      check("pend_start", 64'(snapBUSY),  64'd1);
      check("pend_valid0", 64'(snapVALID), 64'd0);
      wait_end(60, n_cyc);
      check("pend_len",   64'(n_cyc),     64'd33);
      check("pend_done",  64'(snapDONE),  64'd1);
      rdADDR = 4'd7;
      #1;
      check("pend_rd7",   64'(rdDATA),    64'o2000007);

      // Abort in SAMPLE at index 7.
      data_base = 36'o3000000;
      snapREQ   = 1'b1;
      tick();
      snapREQ = 1'b0;
      repeat (15) tick();
      check("ab_addr7",   64'(debugADDR), 64'd7);
      cpuHALT = 1'b0;
      tick();
      check("ab_pulse",   64'(snapABORT), 64'd1);
      check("ab_valid",   64'(snapVALID), 64'd0);
      check("ab_busy",    64'(snapBUSY),  64'd0);
      check("ab_addr",    64'(debugADDR), 64'd1);
      check("ab_done",    64'(snapDONE),  64'd0);
      rdADDR = 4'd7;
      #1;
      check("ab_nowrite", 64'(rdDATA),    64'o2000007);
      rdADDR = 4'd6;
      #1;
      check("ab_rd6",     64'(rdDATA),    64'o3000006);
      tick();
      check("ab_clear",   64'(snapABORT), 64'd0);

      // Counter wrap.
      @(negedge clk);
      force dut.cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_q;
      check("wrap_pre",   64'(instCOUNT), 64'hFFFF_FFFF);
      loadIR = 1'b1;
      tick();
      loadIR = 1'b0;
      check("wrap_zero",  64'(instCOUNT), 64'd0);

      // Asynchronous reset mid-scan.
      cpuHALT   = 1'b1;
      data_base = 36'o5000000;
      loadIR    = 1'b1;
      tick();
      loadIR = 1'b0;
      check("pc_model",   64'(pcOUT),     64'd1);
      snapREQ = 1'b1;
      tick();
      snapREQ = 1'b0;
      repeat (6) tick();
      #2;
      rst = 1'b1;
      #1;
      check("ar_busy",    64'(snapBUSY),  64'd0);
      check("ar_addr",    64'(debugADDR), 64'd1);
      check("ar_pc",      64'(pcOUT),     64'd0);
      check("ar_valid",   64'(snapVALID), 64'd0);
      check("ar_done",    64'(snapDONE),  64'd0);
      check("ar_abort",   64'(snapABORT), 64'd0);
      rdADDR = 4'd1;
      #1;
      check("ar_buf",     64'(rdDATA),    64'd0);
      tick();
      rst = 1'b0;

      // clken freeze in SAMPLE at index 5, then resume.
      data_base = 36'o4000000;
      snapREQ   = 1'b1;
      tick();
      snapREQ = 1'b0;
      repeat (11) tick();
      clken     = 1'b0;
      loadIR    = 1'b1;
      data_base = 36'o7000000;
      repeat (5) tick();
      check("frz_addr",   64'(debugADDR), 64'd5);
      check("frz_busy",   64'(snapBUSY),  64'd1);
      check("frz_cnt",    64'(instCOUNT), 64'd0);
      loadIR    = 1'b0;
      clken     = 1'b1;
      data_base = 36'o4000000;
      wait_end(60, n_cyc);
      check("frz_len",    64'(n_cyc),     64'd22);
      check("frz_done",   64'(snapDONE),  64'd1);
      for (int i = 0; i < 16; i++) begin
         rdADDR = 4'(i);
         #1;
         check($sformatf("frz_rd%0d", i), 64'(rdDATA), 64'o4000000 + 64'(i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
